// File: rtl/touch_ctrl_pkg.sv
// Shared definitions for the two-hand touch controller: state codes,
// default timing constants and the shared-counter width helper.
package touch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    HOLD     = 3'd2,
    FIRE     = 3'd3,
    COOL     = 3'd4,
    WAIT_REL = 3'd5
  } state_t;

  localparam int DEF_DEB_CYCLES    = 16;
  localparam int DEF_WINDOW_CYCLES = 50000;
  localparam int DEF_HOLD_CYCLES   = 100000;
  localparam int DEF_COOL_CYCLES   = 200000;

  // Width of the shared counter, sized by the longest timed state.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// One pad: two-flop synchronizer followed by a stability-count debouncer.
// The output level flips only after DEB_CYCLES consecutive differing samples.
module touch_debounce
  import touch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level
);

  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          meta;
  logic          sync;
  logic [DW-1:0] cnt;

  // NOTE: every register, synchronizer flops included, takes the async reset so
  // a pad held through reset still needs the full sync + debounce delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= pad;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/touch_ctrl.sv
// Two-hand touch controller: debounced pads drive an arm/hold/fire/cooldown
// FSM that emits a single confirm pulse, or a timeout if the second hand is late.
module touch_ctrl
  import touch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int COOL_CYCLES   = DEF_COOL_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch1,
  input  logic       touch2,
  input  logic       enable,
  output logic       confirm,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] touched_db,
  output logic [2:0] state
);

  localparam int CW = cnt_width(WINDOW_CYCLES, HOLD_CYCLES, COOL_CYCLES);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          both;
  logic          none;
  logic          one;

  touch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db1 (
    .clk   (clk),
    .rst   (rst),
    .pad   (touch1),
    .level (touched_db[0])
  );

  touch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db2 (
    .clk   (clk),
    .rst   (rst),
    .pad   (touch2),
    .level (touched_db[1])
  );

  assign both  = &touched_db;
  assign none  = ~|touched_db;
  assign one   = ^touched_db;
  assign busy  = (st != IDLE);
  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      confirm <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the same
      // branch overrides them, so every transition below also clears cnt.
      confirm <= 1'b0;
      timeout <= 1'b0;
      if (cnt != '1) cnt <= cnt + 1'b1;

      unique case (st)
        IDLE: begin
          if (enable && both) begin
            st <= HOLD; cnt <= '0;
          end else if (enable && one) begin
            st <= ARM;  cnt <= '0;
          end
        end
        ARM: begin
          if (!enable || none) begin
            st <= IDLE; cnt <= '0;
          end else if (both) begin
            st <= HOLD; cnt <= '0;
          end else if (cnt == CW'(WINDOW_CYCLES - 1)) begin
            st <= WAIT_REL; cnt <= '0; timeout <= 1'b1;
          end
        end
        HOLD: begin
          // Release or disable beats completion in the same cycle.
          if (!enable || !both) begin
            st <= IDLE; cnt <= '0;
          end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
            st <= FIRE; cnt <= '0; confirm <= 1'b1;
          end
        end
        FIRE: begin
          st  <= enable ? COOL : IDLE;
          cnt <= '0;
        end
        COOL: begin
          // Lockout always runs to completion, regardless of enable or pads.
          if (cnt == CW'(COOL_CYCLES - 1)) begin
            st <= WAIT_REL; cnt <= '0;
          end
        end
        WAIT_REL: begin
          if (!enable || none) begin
            st <= IDLE; cnt <= '0;
          end
        end
        default: begin
          st <= IDLE; cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_ctrl.sv
// Randomized episodes of pad presses, glitches, enable drops and resets,
// checked every cycle against a timestamp-based behavioural model.
module tb_touch_ctrl;

  localparam int DEB   = 4;
  localparam int WIN   = 20;
  localparam int HLD   = 10;
  localparam int COOL  = 8;
  localparam int NEVER = 1000;

  localparam int S_IDLE = 0, S_ARM = 1, S_HOLD = 2, S_FIRE = 3, S_COOL = 4, S_WAIT = 5;

  typedef struct {
    int a1, r1, a2, r2;
    int e0, e1;
    int g_at, g_len;
    int rst_at;
    int len;
  } ep_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       touch1, touch2, enable;
  logic       confirm, timeout, busy;
  logic [1:0] touched_db;
  logic [2:0] state;

  touch_ctrl #(
    .DEB_CYCLES   (DEB),
    .WINDOW_CYCLES(WIN),
    .HOLD_CYCLES  (HLD),
    .COOL_CYCLES  (COOL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .touch1    (touch1),
    .touch2    (touch2),
    .enable    (enable),
    .confirm   (confirm),
    .timeout   (timeout),
    .busy      (busy),
    .touched_db(touched_db),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [7:0] got, input int exp);
    n_checks++;
    if (got !== 8'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw history per pad, state plus the edge it was entered.
  int k;
  bit hist1[$];
  bit hist2[$];
  bit m_db[2];
  int m_st;
  int m_entry;
  bit exp_cf, exp_to;

  function automatic bit samp(input int p, input int edge_no);
    if (edge_no < 1) return 1'b0;
    return (p == 0) ? hist1[edge_no-1] : hist2[edge_no-1];
  endfunction

  task automatic model_reset();
    k = 0;
    hist1.delete();
    hist2.delete();
    m_db[0] = 1'b0;
    m_db[1] = 1'b0;
    m_st    = S_IDLE;
    m_entry = 0;
  endtask

  task automatic model_edge(input bit r1, input bit r2, input bit en);
    bit d1, d2, all_diff;
    int el, nx;
    k++;
    hist1.push_back(r1);
    hist2.push_back(r2);
    d1 = m_db[0];
    d2 = m_db[1];
    el = k - m_entry;
    nx = m_st;
    exp_cf = 1'b0;
    exp_to = 1'b0;
    case (m_st)
      S_IDLE: if (en && d1 && d2) nx = S_HOLD; else if (en && (d1 != d2)) nx = S_ARM;
      S_ARM: begin
        if (!en) nx = S_IDLE;
        else if (d1 && d2) nx = S_HOLD;
        else if (!d1 && !d2) nx = S_IDLE;
        else if (el == WIN) begin nx = S_WAIT; exp_to = 1'b1; end
      end
      S_HOLD: begin
        if (!en || !(d1 && d2)) nx = S_IDLE;
        else if (el == HLD) begin nx = S_FIRE; exp_cf = 1'b1; end
      end
      S_FIRE: nx = en ? S_COOL : S_IDLE;
      S_COOL: if (el == COOL) nx = S_WAIT;
      S_WAIT: if (!en || (!d1 && !d2)) nx = S_IDLE;
      default: nx = S_IDLE;
    endcase
    if (nx != m_st) begin
      m_st    = nx;
      m_entry = k;
    end
    // A pad's level flips once the last DEB synchronized samples all disagree with it.
    for (int p = 0; p < 2; p++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (samp(p, k - 2 - j) == m_db[p]) all_diff = 1'b0;
      if (all_diff) m_db[p] = !m_db[p];
    end
  endtask

  task automatic step(input bit r1, input bit r2, input bit en);
    touch1 = r1;
    touch2 = r2;
    enable = en;
    @(posedge clk);
    #1;
    model_edge(r1, r2, en);
    check("confirm", {7'd0, confirm}, int'(exp_cf));
    check("timeout", {7'd0, timeout}, int'(exp_to));
    check("busy", {7'd0, busy}, (m_st != S_IDLE) ? 1 : 0);
    check("touched_db", {6'd0, touched_db}, {m_db[1], m_db[0]});
    check("state", {5'd0, state}, m_st);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_confirm", {7'd0, confirm}, 0);
    check("rst_timeout", {7'd0, timeout}, 0);
    check("rst_busy", {7'd0, busy}, 0);
    check("rst_touched_db", {6'd0, touched_db}, 0);
    check("rst_state", {5'd0, state}, S_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_ep(input ep_t e);
    bit r1, r2, en;
    for (int t = 0; t < e.len; t++) begin
      r1 = (t >= e.a1 && t < e.r1) ^ (t >= e.g_at && t < e.g_at + e.g_len);
      r2 = (t >= e.a2 && t < e.r2);
      en = !(t >= e.e0 && t < e.e1);
      step(r1, r2, en);
      if (t == e.rst_at) do_reset();
    end
  endtask

  ep_t dir[10];
  ep_t e;
  int  fin;

  initial begin
    touch1 = 1'b0;
    touch2 = 1'b0;
    enable = 1'b1;
    rst    = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    //          a1  r1     a2     r2     e0  e1  g_at g_len rst len
    dir[0] = '{0,  30,    0,     30,    -1, -1, -1,  0,    -1, 50};
    dir[1] = '{0,  40,    10,    40,    -1, -1, -1,  0,    -1, 65};
    dir[2] = '{0,  40,    NEVER, NEVER, -1, -1, -1,  0,    -1, 65};
    dir[3] = '{0,  40,    0,     12,    -1, -1, -1,  0,    -1, 60};
    dir[4] = '{0,  0,     0,     0,     -1, -1, 5,   3,    -1, 20};
    dir[5] = '{0,  30,    0,     30,    -1, -1, 22,  3,    -1, 50};
    dir[6] = '{0,  40,    0,     40,    16, 20, -1,  0,    -1, 60};
    dir[7] = '{0,  40,    0,     40,    18, 25, -1,  0,    -1, 60};
    dir[8] = '{0,  40,    0,     40,    -1, -1, -1,  0,    10, 60};
    dir[9] = '{0,  40,    0,     40,    -1, -1, -1,  0,    16, 60};
    foreach (dir[i]) run_ep(dir[i]);

    for (int n = 0; n < 60; n++) begin
      e.a1 = $urandom_range(0, 5);
      e.r1 = e.a1 + $urandom_range(2, 45);
      if ($urandom_range(0, 3) == 0) begin
        e.a2 = NEVER;
        e.r2 = NEVER;
      end else begin
        e.a2 = e.a1 + $urandom_range(0, 25);
        e.r2 = e.a2 + $urandom_range(2, 45);
      end
      if ($urandom_range(0, 3) == 0) begin
        e.e0 = $urandom_range(0, 40);
        e.e1 = e.e0 + $urandom_range(1, 10);
      end else begin
        e.e0 = -1;
        e.e1 = -1;
      end
      if ($urandom_range(0, 2) == 0) begin
        e.g_at  = $urandom_range(0, 40);
        e.g_len = $urandom_range(1, 3);
      end else begin
        e.g_at  = -1;
        e.g_len = 0;
      end
      e.rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : -1;
      fin = e.r1;
      if (e.a2 != NEVER && e.r2 > fin) fin = e.r2;
      e.len = fin + 30;
      run_ep(e);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
